// File: rtl/dict_attack_ctrl.sv
// Password-recovery sequencer: reads the target hash and key from BRAM, runs one
// decrypt check against EXPECT, then encrypts each dictionary candidate and compares
// the result to the hash.
// Ports:
//   clk, resetB            clock, asynchronous active-low reset
//   start, abort           run request (pulse), abort back to idle (level)
//   mem_addr/mem_en/mem_dout   BRAM read port
//   aes_data/aes_key/aes_decrypt/aes_start/aes_done/aes_result   encrypter handshake
//   state, led             progress code 0..4 and its RGB decode
//   match_addr, timeout    address of the matching entry, sticky AES timeout flag
module dict_attack_ctrl #(
   parameter int unsigned DATA_W     = 128,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DICT_START = 3,
   parameter int unsigned DICT_SIZE  = 4,
   parameter int unsigned BRAM_LAT   = 1,
   parameter int unsigned AES_TMO    = 1024,
   parameter logic [DATA_W-1:0] EXPECT = "Discombobulateme"
) (
   input  logic              clk,
   input  logic              resetB,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_en,
   input  logic [DATA_W-1:0] mem_dout,
   output logic [DATA_W-1:0] aes_data,
   output logic [DATA_W-1:0] aes_key,
   output logic              aes_decrypt,
   output logic              aes_start,
   input  logic              aes_done,
   input  logic [DATA_W-1:0] aes_result,
   output logic [2:0]        state,
   output logic [2:0]        led,
   output logic [ADDR_W-1:0] match_addr,
   output logic              timeout
);

   localparam int unsigned LAT_W    = (BRAM_LAT < 1) ? 1 : $clog2(BRAM_LAT + 1);
   localparam int unsigned TMO_W    = $clog2(AES_TMO + 1);
   localparam int unsigned CAND_W   = (DICT_SIZE < 2) ? 1 : $clog2(DICT_SIZE);
   localparam int unsigned LAST_IDX = (DICT_SIZE == 0) ? 0 : DICT_SIZE - 1;

   typedef enum logic [3:0] {
      IDLE, RD_HASH, RD_KEY, DEC_RUN, DEC_WAIT,
      RD_CAND, ENC_RUN, ENC_WAIT, SUCC, FAIL
   } fsm_t;

   fsm_t              fsm, fsm_nxt;
   logic [LAT_W-1:0]  lat_cnt, lat_nxt;
   logic [TMO_W-1:0]  tmo_cnt, tmo_nxt;
   logic [CAND_W-1:0] cand_idx, cand_nxt;
   logic [DATA_W-1:0] hpass, hpass_nxt;
   logic [ADDR_W-1:0] mem_addr_nxt, match_nxt;
   logic [DATA_W-1:0] aes_data_nxt, aes_key_nxt;
   logic              aes_decrypt_nxt, aes_start_nxt, timeout_nxt;
   logic [2:0]        state_nxt, led_nxt;
   logic              rd_ready, tmo_hit;

   // Dictionary address wraps modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] cand_addr(input logic [CAND_W-1:0] idx);
      return ADDR_W'(DICT_START + 32'(idx));
   endfunction

   function automatic logic [2:0] code_of(input fsm_t s);
      case (s)
         IDLE:                              return 3'd0;
         RD_HASH, RD_KEY, DEC_RUN, DEC_WAIT: return 3'd1;
         RD_CAND, ENC_RUN, ENC_WAIT:        return 3'd2;
         SUCC:                              return 3'd3;
         default:                           return 3'd4;
      endcase
   endfunction

   function automatic logic [2:0] led_of(input logic [2:0] code);
      case (code)
         3'd0:       return 3'b011;
         3'd1, 3'd2: return 3'b100;
         3'd3:       return 3'b010;
         default:    return 3'b001;
      endcase
   endfunction

   assign rd_ready = (lat_cnt == LAT_W'(BRAM_LAT));
   assign tmo_hit  = (tmo_cnt == TMO_W'(AES_TMO - 1));

   // State and output registers.
   always_ff @(posedge clk or negedge resetB) begin
      if (!resetB) begin
         fsm         <= IDLE;
         lat_cnt     <= '0;
         tmo_cnt     <= '0;
         cand_idx    <= '0;
         hpass       <= '0;
         mem_addr    <= '0;
         mem_en      <= 1'b1;
         aes_data    <= '0;
         aes_key     <= '0;
         aes_decrypt <= 1'b1;
         aes_start   <= 1'b0;
         state       <= 3'd0;
         led         <= 3'b011;
         match_addr  <= '0;
         timeout     <= 1'b0;
      end else begin
         fsm         <= fsm_nxt;
         lat_cnt     <= lat_nxt;
         tmo_cnt     <= tmo_nxt;
         cand_idx    <= cand_nxt;
         hpass       <= hpass_nxt;
         mem_addr    <= mem_addr_nxt;
         mem_en      <= 1'b1;
         aes_data    <= aes_data_nxt;
         aes_key     <= aes_key_nxt;
         aes_decrypt <= aes_decrypt_nxt;
         aes_start   <= aes_start_nxt;
         state       <= state_nxt;
         led         <= led_nxt;
         match_addr  <= match_nxt;
         timeout     <= timeout_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      fsm_nxt         = fsm;
      lat_nxt         = lat_cnt;
      tmo_nxt         = tmo_cnt;
      cand_nxt        = cand_idx;
      hpass_nxt       = hpass;
      mem_addr_nxt    = mem_addr;
      aes_data_nxt    = aes_data;
      aes_key_nxt     = aes_key;
      aes_decrypt_nxt = aes_decrypt;
      aes_start_nxt   = 1'b0;
      match_nxt       = match_addr;
      timeout_nxt     = timeout;

      if (abort && fsm != IDLE) begin
         // Abort wins over everything, including a same-cycle start or aes_done.
         fsm_nxt      = IDLE;
         mem_addr_nxt = '0;
      end else begin
         case (fsm)
            IDLE: begin
               if (start && !abort) begin
                  fsm_nxt      = RD_HASH;
                  lat_nxt      = '0;
                  mem_addr_nxt = '0;
               end
            end
            RD_HASH: begin
               if (rd_ready) begin
                  hpass_nxt    = mem_dout;
                  fsm_nxt      = RD_KEY;
                  mem_addr_nxt = ADDR_W'(1);
                  lat_nxt      = '0;
               end else begin
                  lat_nxt = lat_cnt + LAT_W'(1);
               end
            end
            RD_KEY: begin
               if (rd_ready) begin
                  aes_key_nxt     = mem_dout;
                  aes_data_nxt    = hpass;
                  aes_decrypt_nxt = 1'b1;
                  aes_start_nxt   = 1'b1;
                  fsm_nxt         = DEC_RUN;
               end else begin
                  lat_nxt = lat_cnt + LAT_W'(1);
               end
            end
            DEC_RUN: begin
               fsm_nxt = DEC_WAIT;
               tmo_nxt = '0;
            end
            DEC_WAIT: begin
               if (aes_done) begin
                  if (aes_result == EXPECT) begin
                     fsm_nxt      = SUCC;
                     match_nxt    = '0;
                     mem_addr_nxt = '0;
                  end else begin
                     cand_nxt        = '0;
                     aes_decrypt_nxt = 1'b0;
                     if (DICT_SIZE == 0) begin
                        fsm_nxt      = FAIL;
                        mem_addr_nxt = '0;
                     end else begin
                        fsm_nxt      = RD_CAND;
                        mem_addr_nxt = cand_addr('0);
                        lat_nxt      = '0;
                     end
                  end
               end else if (tmo_hit) begin
                  fsm_nxt      = FAIL;
                  timeout_nxt  = 1'b1;
                  mem_addr_nxt = '0;
               end else begin
                  tmo_nxt = tmo_cnt + TMO_W'(1);
               end
            end
            RD_CAND: begin
               if (rd_ready) begin
                  aes_data_nxt  = mem_dout;
                  aes_start_nxt = 1'b1;
                  fsm_nxt       = ENC_RUN;
               end else begin
                  lat_nxt = lat_cnt + LAT_W'(1);
               end
            end
            ENC_RUN: begin
               fsm_nxt = ENC_WAIT;
               tmo_nxt = '0;
            end
            ENC_WAIT: begin
               if (aes_done) begin
                  if (aes_result == hpass) begin
                     fsm_nxt      = SUCC;
                     match_nxt    = mem_addr;
                     mem_addr_nxt = '0;
                  end else if (cand_idx == CAND_W'(LAST_IDX)) begin
                     fsm_nxt      = FAIL;
                     mem_addr_nxt = '0;
                  end else begin
                     cand_nxt     = cand_idx + CAND_W'(1);
                     mem_addr_nxt = cand_addr(cand_idx + CAND_W'(1));
                     fsm_nxt      = RD_CAND;
                     lat_nxt      = '0;
                  end
               end else if (tmo_hit) begin
                  fsm_nxt      = FAIL;
                  timeout_nxt  = 1'b1;
                  mem_addr_nxt = '0;
               end else begin
                  tmo_nxt = tmo_cnt + TMO_W'(1);
               end
            end
            SUCC, FAIL: begin
               if (start) begin
                  fsm_nxt      = RD_HASH;
                  lat_nxt      = '0;
                  timeout_nxt  = 1'b0;
                  match_nxt    = '0;
                  mem_addr_nxt = '0;
               end
            end
            default: fsm_nxt = IDLE;
         endcase
      end

      state_nxt = code_of(fsm_nxt);
      led_nxt   = led_of(state_nxt);
   end

endmodule

// File: tb/tb_dict_attack_ctrl.sv
// Self-checking bench for dict_attack_ctrl: BRAM and encrypter models (encrypter
// result = data ^ key), a table of whole-run vectors, and directed multi-cycle cases.
module tb_dict_attack_ctrl;
   localparam logic [127:0] EXP = "Discombobulateme";
   localparam logic [127:0] NOHASH = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

   logic         clk = 1'b0, resetB = 1'b0, start = 1'b0, abort = 1'b0, start0 = 1'b0;
   logic [7:0]   mem_addr, match_addr, mem_addr0, match_addr0;
   logic         mem_en, aes_decrypt, aes_start, timeout;
   logic         mem_en0, aes_decrypt0, aes_start0, timeout0;
   logic [127:0] mem_dout, aes_data, aes_key, aes_result;
   logic [127:0] mem_dout0, aes_data0, aes_key0;
   logic [127:0] aes_result0 = '0;
   logic         aes_done = 1'b0, aes_done0 = 1'b0, d1_0 = 1'b0;
   logic [2:0]   state, led, state0, led0;
   logic [127:0] mem [256];

   int n_checks = 0, n_fail = 0;
   int aes_lat = 1;
   bit withhold = 0;
   int start_pulses = 0, start_pulses0 = 0, succ_entries = 0, st2_visits0 = 0;
   logic [15:0] seq = '0;
   logic [2:0]  last_st = 3'd0;

   always #5 clk = ~clk;

   dict_attack_ctrl u_dut (
      .clk(clk), .resetB(resetB), .start(start), .abort(abort),
      .mem_addr(mem_addr), .mem_en(mem_en), .mem_dout(mem_dout),
      .aes_data(aes_data), .aes_key(aes_key), .aes_decrypt(aes_decrypt),
      .aes_start(aes_start), .aes_done(aes_done), .aes_result(aes_result),
      .state(state), .led(led), .match_addr(match_addr), .timeout(timeout));

   dict_attack_ctrl #(.DICT_SIZE(0)) u_dut0 (
      .clk(clk), .resetB(resetB), .start(start0), .abort(abort),
      .mem_addr(mem_addr0), .mem_en(mem_en0), .mem_dout(mem_dout0),
      .aes_data(aes_data0), .aes_key(aes_key0), .aes_decrypt(aes_decrypt0),
      .aes_start(aes_start0), .aes_done(aes_done0), .aes_result(aes_result0),
      .state(state0), .led(led0), .match_addr(match_addr0), .timeout(timeout0));

   // BRAM with one cycle of read latency.
   always @(posedge clk) begin
      mem_dout  <= mem[mem_addr];
      mem_dout0 <= mem[mem_addr0];
   end

   // Encrypter model: done aes_lat+1 cycles after the start pulse unless withheld.
   logic         pend = 1'b0;
   int           cnt = 0;
   logic [127:0] res = '0;
   always @(posedge clk or negedge resetB) begin
      if (!resetB) begin
         pend <= 1'b0; cnt <= 0; aes_done <= 1'b0; aes_result <= '0;
      end else begin
         aes_done <= 1'b0;
         if (aes_start) begin
            pend <= 1'b1; cnt <= aes_lat; res <= aes_data ^ aes_key;
         end else if (pend) begin
            if (cnt == 0) begin
               pend <= 1'b0; aes_done <= !withhold; aes_result <= res;
            end else cnt <= cnt - 1;
         end
      end
   end

   // Second encrypter model: always answers with a non-matching result.
   always @(posedge clk) begin
      d1_0 <= aes_start0;
      aes_done0 <= d1_0;
   end

   always @(posedge clk) begin
      if (aes_start === 1'b1)  start_pulses  <= start_pulses + 1;
      if (aes_start0 === 1'b1) start_pulses0 <= start_pulses0 + 1;
   end

   // State-code history (4 bits per distinct code, cleared on return to 0).
   always @(negedge clk) begin
      if (state !== last_st) begin
         if (state == 3'd0) seq <= '0;
         else seq <= {seq[11:0], 1'b0, state};
         if (state == 3'd3) succ_entries <= succ_entries + 1;
         last_st <= state;
      end
      if (state0 == 3'd2) st2_visits0 <= st2_visits0 + 1;
   end

   typedef struct {
      int           sel;
      logic [127:0] key;
      logic [2:0]   st;
      logic [2:0]   led;
      logic [7:0]   match;
      int           pulses;
      logic [15:0]  seq;
   } vec_t;
   vec_t vecs[5];

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic load(input int sel, input logic [127:0] key);
      mem[1] = key;
      if (sel == 0)                 mem[0] = EXP ^ key;
      else if (sel >= 3 && sel <= 6) mem[0] = mem[sel] ^ key;
      else                          mem[0] = NOHASH;
   endtask

   task automatic do_reset(input int sel, input logic [127:0] key);
      @(negedge clk) resetB = 1'b0;
      load(sel, key);
      repeat (2) @(negedge clk);
      resetB = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_final(input int max, input string nm);
      int n = 0;
      while (state != 3'd3 && state != 3'd4 && n < max) begin
         @(negedge clk);
         n++;
      end
      if (state != 3'd3 && state != 3'd4) begin
         n_checks++; n_fail++;
         $display("FAIL %s: no final state after %0d cycles, state=%0d", nm, max, state);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_reset_vals(input string p);
      check({p, "_state"}, state, 3'd0);
      check({p, "_led"}, led, 3'b011);
      check({p, "_mem_addr"}, mem_addr, 8'd0);
      check({p, "_mem_en"}, mem_en, 1'b1);
      check({p, "_aes_start"}, aes_start, 1'b0);
      check({p, "_aes_decrypt"}, aes_decrypt, 1'b1);
      check({p, "_aes_data"}, aes_data, 128'd0);
      check({p, "_aes_key"}, aes_key, 128'd0);
      check({p, "_match"}, match_addr, 8'd0);
      check({p, "_timeout"}, timeout, 1'b0);
   endtask

   initial begin
      int base, sc, n;
      for (int i = 0; i < 256; i++) mem[i] = {4{(32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F}};

      vecs[0] = '{0,   128'h1111_2222_3333_4444_5555_6666_7777_8888, 3'd3, 3'b010, 8'd0, 1, 16'h0013};
      vecs[1] = '{5,   128'hA5A5_0000_FFFF_1234_0BAD_CAFE_DEAD_BEEF, 3'd3, 3'b010, 8'd5, 4, 16'h0123};
      vecs[2] = '{3,   128'h0F0F_F0F0_1357_9BDF_2468_ACE0_0000_0001, 3'd3, 3'b010, 8'd3, 2, 16'h0123};
      vecs[3] = '{6,   128'h7777_0000_8888_0000_9999_0000_AAAA_0000, 3'd3, 3'b010, 8'd6, 5, 16'h0123};
      vecs[4] = '{255, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 3'd4, 3'b001, 8'd0, 5, 16'h0124};

      #12;
      check_reset_vals("reset");

      for (int v = 0; v < 5; v++) begin
         do_reset(vecs[v].sel, vecs[v].key);
         base = start_pulses;
         pulse_start();
         wait_final(300, $sformatf("v%0d_run", v));
         check($sformatf("v%0d_state", v), state, vecs[v].st);
         check($sformatf("v%0d_led", v), led, vecs[v].led);
         check($sformatf("v%0d_match", v), match_addr, vecs[v].match);
         check($sformatf("v%0d_pulses", v), start_pulses - base, vecs[v].pulses);
         check($sformatf("v%0d_seq", v), seq, vecs[v].seq);
         check($sformatf("v%0d_timeout", v), timeout, 1'b0);
         check($sformatf("v%0d_mem_addr", v), mem_addr, 8'd0);
      end

      // start pulses during a run are ignored
      do_reset(5, 128'hA5A5_0000_FFFF_1234_0BAD_CAFE_DEAD_BEEF);
      base = start_pulses;
      pulse_start();
      repeat (2) @(negedge clk);
      pulse_start();
      repeat (5) @(negedge clk);
      pulse_start();
      repeat (3) @(negedge clk);
      pulse_start();
      wait_final(300, "busy_run");
      check("busy_pulses", start_pulses - base, 4);
      check("busy_match", match_addr, 8'd5);
      check("busy_seq", seq, 16'h0123);

      // new run from SUCC clears match_addr
      mem[0] = NOHASH;
      base = start_pulses;
      pulse_start();
      check("restart_state", state, 3'd1);
      check("restart_match", match_addr, 8'd0);
      wait_final(300, "restart_run");
      check("restart_final", state, 3'd4);
      check("restart_pulses", start_pulses - base, 5);

      // withheld aes_done: FAIL exactly 1024 cycles after entering DEC_WAIT
      do_reset(0, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
      withhold = 1;
      pulse_start();
      n = 0;
      while (aes_start !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("tmo_saw_start", aes_start, 1'b1);
      repeat (1024) @(negedge clk);
      check("tmo_before", state, 3'd1);
      @(negedge clk);
      check("tmo_state", state, 3'd4);
      check("tmo_flag", timeout, 1'b1);
      check("tmo_led", led, 3'b001);
      withhold = 0;
      repeat (2) @(negedge clk);
      pulse_start();
      repeat (2) @(negedge clk);
      check("tmo_cleared", timeout, 1'b0);
      check("tmo_rerun_state", state, 3'd1);
      wait_final(300, "tmo_rerun");
      check("tmo_rerun_final", state, 3'd3);

      // abort during ENC_WAIT, late aes_done must not reach SUCC
      do_reset(3, 128'h0F0F_F0F0_1357_9BDF_2468_ACE0_0000_0001);
      aes_lat = 10;
      pulse_start();
      n = 0;
      while (!(state == 3'd2 && aes_start === 1'b1) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("abort_reached_enc", state, 3'd2);
      sc = succ_entries;
      repeat (2) @(negedge clk);
      abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      check("abort_state", state, 3'd0);
      check("abort_led", led, 3'b011);
      check("abort_mem_addr", mem_addr, 8'd0);
      check("abort_aes_start", aes_start, 1'b0);
      repeat (20) @(negedge clk);
      check("abort_late_state", state, 3'd0);
      check("abort_no_succ", succ_entries - sc, 0);
      aes_lat = 1;

      // resetB low mid-run
      do_reset(5, 128'hA5A5_0000_FFFF_1234_0BAD_CAFE_DEAD_BEEF);
      pulse_start();
      repeat (14) @(negedge clk);
      check("midrun_busy", state, 3'd2);
      resetB = 1'b0;
      #1;
      check_reset_vals("midrun");
      @(negedge clk) resetB = 1'b1;

      // DICT_SIZE=0 instance: FAIL straight from DEC_WAIT
      mem[0] = NOHASH;
      mem[1] = 128'hFACE_FACE_0000_1111_2222_3333_4444_5555;
      @(negedge clk) start0 = 1'b1;
      @(negedge clk) start0 = 1'b0;
      n = 0;
      while (state0 != 3'd4 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("d0_state", state0, 3'd4);
      check("d0_led", led0, 3'b001);
      check("d0_no_cand", st2_visits0, 0);
      check("d0_pulses", start_pulses0, 1);
      check("d0_timeout", timeout0, 1'b0);
      check("d0_mem_addr", mem_addr0, 8'd0);
      check("d0_match", match_addr0, 8'd0);
      check("d0_decrypt", aes_decrypt0, 1'b0);
      check("d0_key", aes_key0, 128'hFACE_FACE_0000_1111_2222_3333_4444_5555);
      check("d0_data", aes_data0, NOHASH);
      check("d0_mem_en", mem_en0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard bound on total run time.
   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "global timeout");
   end
endmodule
